// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the cache hierarchy, including the L2 arbiter.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int unsigned L2_LINE_W = 256;

  typedef logic [L2_LINE_W-1:0] lc3b_l2_line;

  // Arbiter FSM: wait for a request, hold one L2 transaction, then one bubble.
  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RELEASE
  } l2_arb_state_t;

  // Which L1 port currently owns (or last owned) the L2 interface.
  typedef enum logic {
    PORT_I,
    PORT_D
  } l2_arb_port_t;

endpackage

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the single L2 interface between the L1 I-cache
// and D-cache miss paths. One transaction is outstanding at a time; the
// winning request is captured into registers that drive the L2 port.
module l2_arbiter
  import lc3b_types::*;
#(
  parameter int width = L2_LINE_W
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_read,
  input  lc3b_word         i_address,
  output logic             i_resp,
  output logic [width-1:0] i_rdata,

  input  logic             d_read,
  input  logic             d_write,
  input  lc3b_word         d_address,
  input  logic [width-1:0] d_wdata,
  output logic             d_resp,
  output logic [width-1:0] d_rdata,

  output logic             l2_read,
  output logic             l2_write,
  output lc3b_word         l2_address,
  output logic [width-1:0] l2_wdata,
  input  logic             l2_resp,
  input  logic [width-1:0] l2_rdata
);

  l2_arb_state_t    state_q, state_d;
  l2_arb_port_t     last_grant_q, last_grant_d;
  lc3b_word         addr_q, addr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic             l2_read_q, l2_read_d;
  logic             l2_write_q, l2_write_d;

  logic i_pend;
  logic d_pend;
  logic pick_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  // D wins when it is the only requester, or on a tie when I was served last.
  assign pick_d = d_pend && (!i_pend || (last_grant_q == PORT_I));

  // Next-state and capture logic for the FSM and request registers.
  always_comb begin
    // NOTE: every next value starts as its hold value so no path leaves it unassigned (no latch).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          addr_d       = d_address;
          wdata_d      = d_wdata;
          // A write-back takes precedence when both D ops are raised together.
          l2_write_d   = d_write;
          l2_read_d    = !d_write;
          last_grant_d = PORT_D;
          state_d      = SERVE_D;
        end else if (i_pend) begin
          addr_d       = i_address;
          l2_write_d   = 1'b0;
          l2_read_d    = 1'b1;
          last_grant_d = PORT_I;
          state_d      = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (l2_resp) begin
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        // Bubble so the served requester can drop its level request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the wide line register is reset too, because its value is visible on l2_wdata after reset.
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
    end
  end

  assign l2_read    = l2_read_q;
  assign l2_write   = l2_write_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  // Completion is forwarded combinationally, only to the port being served.
  assign i_resp  = (state_q == SERVE_I) && l2_resp;
  assign d_resp  = (state_q == SERVE_D) && l2_resp;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule
